// File: rtl/seq_stage_ctrl_pkg.sv
// Shared Y86-64 SEQ definitions: status codes, instruction codes and sequencer states.
package seq_stage_ctrl_pkg;

  typedef enum logic [1:0] {
    STAT_AOK = 2'd0,
    STAT_HLT = 2'd1,
    STAT_ADR = 2'd2,
    STAT_INS = 2'd3
  } stat_t;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRBACK, S_PCUPD, S_STOP
  } state_t;

  // Instructions that touch data memory and therefore need the MEMORY stage.
  function automatic logic is_mem_op(input logic [3:0] icode);
    return icode inside {IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ};
  endfunction

  // One-hot {f,d,e,m,w,pc} enables for a state; idle/stop states drive none.
  function automatic logic [5:0] stage_en(input state_t s);
    logic [5:0] en;
    en = '0;
    case (s)
      S_FETCH:   en = 6'b100000;
      S_DECODE:  en = 6'b010000;
      S_EXECUTE: en = 6'b001000;
      S_MEMORY:  en = 6'b000100;
      S_WRBACK:  en = 6'b000010;
      S_PCUPD:   en = 6'b000001;
      default:   en = '0;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/seq_stage_ctrl_mem_wait.sv
// Request/acknowledge wait counter shared by the FETCH and MEMORY handshakes.
module seq_mem_wait #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic ack,
  output logic timeout
);

  localparam logic [3:0] LAST_WAIT = 4'(MEM_TIMEOUT - 1);

  logic [3:0] wait_cnt;

  // FETCH and MEMORY are never adjacent, so clearing while inactive gives a fresh count on entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       wait_cnt <= '0;
    else if (!active) wait_cnt <= '0;
    else if (!ack)    wait_cnt <= wait_cnt + 4'd1;
  end

  assign timeout = active && !ack && (wait_cnt == LAST_WAIT);

endmodule

// File: rtl/seq_stage_ctrl.sv
// Multi-cycle sequencer for the Y86-64 SEQ datapath: stage enables, memory handshakes,
// status latching, run/step control and retired-instruction/cycle counters.
module seq_stage_ctrl
  import seq_stage_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step_mode,
  input  logic [3:0]       icode,
  input  logic             halt,
  input  logic             invalid_inst,
  input  logic             imem_error,
  input  logic             dmem_error,
  input  logic             if_ack,
  input  logic             dm_ack,
  output logic             f_en,
  output logic             d_en,
  output logic             e_en,
  output logic             m_en,
  output logic             w_en,
  output logic             pc_en,
  output logic             if_req,
  output logic             dm_req,
  output logic [1:0]       stat,
  output logic             busy,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] cycle_count
);

  state_t state, state_nxt;
  stat_t  stat_q, stat_nxt;
  logic   retire;
  logic   wait_active, wait_ack, timeout;

  assign wait_active = (state == S_FETCH) || (state == S_MEMORY);
  assign wait_ack    = (state == S_FETCH) ? if_ack : dm_ack;

  seq_mem_wait #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_mem_wait (
    .clk     (clk),
    .rst_n   (rst_n),
    .active  (wait_active),
    .ack     (wait_ack),
    .timeout (timeout)
  );

  always_comb begin
    state_nxt = state;
    stat_nxt  = stat_q;
    retire    = 1'b0;
    case (state)
      S_IDLE:    if (start) state_nxt = S_FETCH;
      S_FETCH: begin
        if (if_ack) begin
          if (imem_error) begin
            stat_nxt  = STAT_ADR;
            state_nxt = S_STOP;
          end else if (invalid_inst) begin
            stat_nxt  = STAT_INS;
            state_nxt = S_STOP;
          end else if (halt) begin
            stat_nxt  = STAT_HLT;
            state_nxt = S_STOP;
            retire    = 1'b1;
          end else begin
            state_nxt = S_DECODE;
          end
        end else if (timeout) begin
          stat_nxt  = STAT_ADR;
          state_nxt = S_STOP;
        end
      end
      S_DECODE:  state_nxt = S_EXECUTE;
      S_EXECUTE: state_nxt = is_mem_op(icode) ? S_MEMORY : S_WRBACK;
      S_MEMORY: begin
        if (dm_ack) begin
          if (dmem_error) begin
            stat_nxt  = STAT_ADR;
            state_nxt = S_STOP;
          end else begin
            state_nxt = S_WRBACK;
          end
        end else if (timeout) begin
          stat_nxt  = STAT_ADR;
          state_nxt = S_STOP;
        end
      end
      S_WRBACK:  state_nxt = S_PCUPD;
      S_PCUPD: begin
        retire    = 1'b1;
        state_nxt = step_mode ? S_IDLE : S_FETCH;
      end
      S_STOP:    state_nxt = S_STOP;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so every enable/request is a flop output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      stat_q      <= STAT_AOK;
      {f_en, d_en, e_en, m_en, w_en, pc_en} <= '0;
      if_req      <= 1'b0;
      dm_req      <= 1'b0;
      busy        <= 1'b0;
      instr_count <= '0;
      cycle_count <= '0;
    end else begin
      state  <= state_nxt;
      stat_q <= stat_nxt;
      {f_en, d_en, e_en, m_en, w_en, pc_en} <= stage_en(state_nxt);
      if_req <= (state_nxt == S_FETCH);
      dm_req <= (state_nxt == S_MEMORY);
      busy   <= (stage_en(state_nxt) != '0);
      if (busy)   cycle_count <= cycle_count + CNT_W'(1);
      if (retire) instr_count <= instr_count + CNT_W'(1);
    end
  end

  assign stat = stat_q;

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// Scoreboard bench for seq_stage_ctrl: per-instruction stage traces, status and counters.
`timescale 1ns/1ps
module tb_seq_stage_ctrl;

  localparam int TMO = 15;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, step_mode = 1'b0;
  logic [3:0]  icode = '0;
  logic        halt = 1'b0, invalid_inst = 1'b0, imem_error = 1'b0, dmem_error = 1'b0;
  logic        if_ack = 1'b0, dm_ack = 1'b0;
  logic        f_en, d_en, e_en, m_en, w_en, pc_en, if_req, dm_req, busy;
  logic [1:0]  stat;
  logic [31:0] instr_count, cycle_count;

  seq_stage_ctrl #(.CNT_W(32), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .step_mode(step_mode), .icode(icode),
    .halt(halt), .invalid_inst(invalid_inst), .imem_error(imem_error), .dmem_error(dmem_error),
    .if_ack(if_ack), .dm_ack(dm_ack), .f_en(f_en), .d_en(d_en), .e_en(e_en), .m_en(m_en),
    .w_en(w_en), .pc_en(pc_en), .if_req(if_req), .dm_req(dm_req), .stat(stat), .busy(busy),
    .instr_count(instr_count), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       trace;
    logic [1:0]  stat;
    int unsigned instr;
    int unsigned cycles;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0, errors = 0;
  int unsigned m_instr = 0, m_cycles = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: expected stage trace and architectural totals for one instruction.
  task automatic model_push(input logic [3:0] ic, input int fw, input int dw,
                            input logic imem, input logic inv, input logic hlt, input logic dmem,
                            output bit stopped, output logic [1:0] est);
    exp_t e;
    int   n;
    e.trace = "";
    e.stat  = 2'd0;
    stopped = 0;
    n = (fw >= TMO) ? TMO : fw + 1;
    repeat (n) e.trace = {e.trace, "F"};
    if (fw >= TMO || imem) begin e.stat = 2'd2; stopped = 1; end
    else if (inv)          begin e.stat = 2'd3; stopped = 1; end
    else if (hlt)          begin e.stat = 2'd1; stopped = 1; m_instr++; end
    else begin
      e.trace = {e.trace, "DE"};
      if (ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB}) begin
        n = (dw >= TMO) ? TMO : dw + 1;
        repeat (n) e.trace = {e.trace, "M"};
        if (dw >= TMO || dmem) begin e.stat = 2'd2; stopped = 1; end
      end
      if (!stopped) begin e.trace = {e.trace, "WP"}; m_instr++; end
    end
    m_cycles += e.trace.len();
    e.instr  = m_instr;
    e.cycles = m_cycles;
    est      = e.stat;
    sb.push_back(e);
  endtask

  // Monitor: builds the observed trace and scores it when an instruction ends.
  initial begin
    string trace;
    bit    prev_busy, prev_pc;
    exp_t  e;
    trace = ""; prev_busy = 0; prev_pc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        trace = ""; prev_busy = 0; prev_pc = 0;
      end else begin
        if (prev_pc || (prev_busy && busy !== 1'b1)) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_unexpected actual=%s expected=none", trace);
          end else begin
            e = sb.pop_front();
            checks++;
            if (trace != e.trace) begin
              errors++;
              $display("FAIL trace actual=%s expected=%s", trace, e.trace);
            end
            check("stat", 64'(stat), 64'(e.stat));
            check("instr_count", 64'(instr_count), 64'(e.instr));
            check("cycle_count", 64'(cycle_count), 64'(e.cycles));
          end
          trace = "";
        end
        check("onehot_en", 64'($countones({f_en, d_en, e_en, m_en, w_en, pc_en})), 64'(busy));
        check("req_vs_en", 64'({if_req, dm_req}), 64'({f_en, m_en}));
        if (busy === 1'b1)
          trace = {trace, f_en ? "F" : d_en ? "D" : e_en ? "E" : m_en ? "M" : w_en ? "W" : pc_en ? "P" : "?"};
        prev_busy = (busy === 1'b1);
        prev_pc   = (pc_en === 1'b1);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; if_ack = 1'b0; dm_ack = 1'b0;
    halt = 1'b0; invalid_inst = 1'b0; imem_error = 1'b0; dmem_error = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({f_en, d_en, e_en, m_en, w_en, pc_en, if_req, dm_req, busy, stat}), 64'(0));
    check("reset_counters", {instr_count, cycle_count}, 64'(0));
    if (sb.size() != 0) begin
      check("sb_leftover", 64'(sb.size()), 64'(0));
      sb.delete();
    end
    m_instr = 0; m_cycles = 0;
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_req(input bit dm, output bit ok);
    ok = 0;
    for (int k = 0; k < 60; k++) begin
      if ((dm ? dm_req : if_req) === 1'b1) begin ok = 1; return; end
      @(negedge clk);
    end
    checks++; errors++;
    $display("FAIL wait_%s actual=timeout required=request", dm ? "dm_req" : "if_req");
  endtask

  task automatic wait_done();
    for (int k = 0; k < 60; k++) begin
      if (pc_en === 1'b1) begin @(negedge clk); return; end
      if (busy !== 1'b1) return;
      @(negedge clk);
    end
    checks++; errors++;
    $display("FAIL wait_done actual=timeout required=retire_or_stop");
  endtask

  task automatic issue(input logic [3:0] ic, input int fw, input int dw, input logic imem,
                       input logic inv, input logic hlt, input logic dmem, input logic step);
    bit         stopped, ok, fstop;
    logic [1:0] est;
    model_push(ic, fw, dw, imem, inv, hlt, dmem, stopped, est);
    fstop = (fw >= TMO) || imem || inv || hlt;
    step_mode = step;
    if (busy !== 1'b1) begin start = 1'b1; @(negedge clk); start = 1'b0; end
    wait_req(0, ok);
    if (!ok) begin do_reset(); return; end
    icode = ic;
    for (int c = 0; ; c++) begin
      if_ack       = (c == fw);
      imem_error   = (c == fw) ? imem : 1'($urandom);
      invalid_inst = (c == fw) ? inv  : 1'($urandom);
      halt         = (c == fw) ? hlt  : 1'($urandom);
      @(negedge clk);
      if (c == fw || c == TMO - 1) break;
    end
    if_ack = 1'b0; imem_error = 1'b0; invalid_inst = 1'b0; halt = 1'b0;
    if (!fstop && (ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB})) begin
      wait_req(1, ok);
      if (!ok) begin do_reset(); return; end
      for (int c = 0; ; c++) begin
        dm_ack     = (c == dw);
        dmem_error = (c == dw) ? dmem : 1'($urandom);
        @(negedge clk);
        if (c == dw || c == TMO - 1) break;
      end
      dm_ack = 1'b0; dmem_error = 1'b0;
    end
    wait_done();
    if (stopped) begin
      start = 1'b1; @(negedge clk); start = 1'b0;
      repeat (3) @(negedge clk);
      check("stop_ignores_start", 64'(busy), 64'(0));
      check("stop_holds_stat", 64'(stat), 64'(est));
      do_reset();
    end
  endtask

  function automatic int rand_wait();
    int r;
    r = int'($urandom_range(0, 19));
    if (r < 16)  return r % 4;
    if (r == 16) return TMO - 1;
    if (r == 17) return TMO;
    if (r == 18) return int'($urandom_range(0, TMO - 2));
    return TMO + 5;
  endfunction

  initial begin
    bit bad;
    do_reset();
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy !== 1'b0 || stat !== 2'd0 || instr_count !== 0 || cycle_count !== 0) bad = 1;
    end
    check("idle_no_start", 64'(bad), 64'(0));

    issue(4'h6, 1, 0, 0, 0, 0, 0, 0);
    issue(4'h4, 0, 3, 0, 0, 0, 0, 0);
    do_reset();

    issue(4'h2, 0, 0, 0, 0, 0, 0, 1);
    issue(4'h5, 2, 1, 0, 0, 0, 0, 1);
    issue(4'h7, 1, 0, 0, 0, 0, 0, 1);
    issue(4'h0, 0, 0, 0, 0, 1, 0, 1);

    issue(4'h4, 0, TMO + 5, 0, 0, 0, 0, 0);
    issue(4'h1, 0, 0, 0, 1, 1, 0, 0);
    issue(4'h3, 0, 0, 1, 1, 1, 0, 0);
    issue(4'h6, TMO - 1, 0, 0, 0, 0, 0, 1);
    issue(4'hA, 0, TMO - 1, 0, 0, 0, 0, 1);
    issue(4'h6, TMO, 0, 0, 0, 0, 0, 0);
    issue(4'h8, 2, 1, 0, 0, 0, 1, 0);

    // Asynchronous reset while MEMORY waits on dm_ack.
    begin
      bit ok;
      start = 1'b1; @(negedge clk); start = 1'b0;
      wait_req(0, ok);
      icode = 4'h4; if_ack = 1'b1; @(negedge clk); if_ack = 1'b0;
      wait_req(1, ok);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check("async_reset_mid_mem", 64'({f_en, d_en, e_en, m_en, w_en, pc_en, if_req, dm_req, busy, stat}), 64'(0));
      check("async_reset_counters", {instr_count, cycle_count}, 64'(0));
      @(negedge clk); #1 rst_n = 1'b1;
      m_instr = 0; m_cycles = 0;
    end

    for (int i = 0; i < 80; i++) begin
      issue(4'($urandom_range(0, 15)), rand_wait(), rand_wait(),
            ($urandom_range(0, 11) == 0), ($urandom_range(0, 11) == 0),
            ($urandom_range(0, 11) == 0), ($urandom_range(0, 11) == 0),
            ($urandom_range(0, 2) == 0));
    end
    do_reset();
    check("sb_drained", 64'(sb.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
